// File: rtl/instr_exec_unit.sv
// Execute stage: 1-cycle simple ops, MULT_LAT-cycle MULT, 33-cycle restoring DIV/MOD.
// One instruction in flight; in_ready drops until the result handshakes. EXEC_STATS_EN adds stat counters.
module instr_exec_unit #(
  parameter int MULT_LAT  = 3,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opc,
  input  logic [31:0] in_op_a,
  input  logic [31:0] in_op_b,
  input  logic [4:0]  in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_res,
  output logic [4:0]  out_addr,
  output logic        out_err
`ifdef EXEC_STATS_EN
  ,
  output logic [31:0] stat_done,
  output logic [15:0] stat_err
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MULT_LAT - 2);
  localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

  state_t      state, state_nxt;
  logic        up_q;
  logic [4:0]  cnt;
  logic [63:0] res_q;
  logic [4:0]  addr_q;
  logic        err_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        a_neg_q, q_neg_q, is_mod_q;

  logic        accept, is_div_op, go_div, go_mul;
  logic [63:0] a_ext, b_ext, simple_res;
  logic        simple_err;
  logic [32:0] rem_sh, diff;
  logic        step_ge;
  logic [31:0] rem_new, quo_new;
  logic [63:0] div_mag, div_res;

  assign in_ready  = (state == IDLE) && up_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_res   = res_q;
  assign out_addr  = addr_q;
  assign out_err   = err_q;

  assign is_div_op = (in_opc == 4'd6) || (in_opc == 4'd7);
  assign go_div    = is_div_op && (in_op_b != 32'd0);
  assign go_mul    = (in_opc == 4'd5);
  assign a_ext     = {{32{in_op_a[31]}}, in_op_a};
  assign b_ext     = {{32{in_op_b[31]}}, in_op_b};

  // Low 64 bits of the product are sign-agnostic, so the sign-extended operands suffice.
  always_comb begin
    simple_res = '0;
    simple_err = 1'b0;
    case (in_opc)
      4'd0: simple_res = '0;
      4'd1: simple_res = a_ext;
      4'd2: simple_res = b_ext;
      4'd3: simple_res = a_ext + b_ext;
      4'd4: simple_res = a_ext - b_ext;
      4'd5: simple_res = a_ext * b_ext;
      4'd6, 4'd7: simple_err = (in_op_b == 32'd0);
      default: simple_err = 1'b1;
    endcase
  end

  // One restoring step on magnitudes; the final step feeds the sign fix-up directly.
  assign rem_sh  = {rem_q, quo_q[31]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign step_ge = !diff[32];
  assign rem_new = step_ge ? diff[31:0] : rem_sh[31:0];
  assign quo_new = {quo_q[30:0], step_ge};
  assign div_mag = is_mod_q ? {32'd0, rem_new} : {32'd0, quo_new};
  assign div_res = (is_mod_q ? a_neg_q : q_neg_q) ? -div_mag : div_mag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (go_mul && (MULT_LAT > 1)) state_nxt = MUL;
        else if (go_div)              state_nxt = DIV;
        else                          state_nxt = DONE;
      end
      MUL:  if (cnt == MUL_LAST) state_nxt = DONE;
      DIV:  if (cnt == DIV_LAST) state_nxt = DONE;
      DONE: if (out_ready)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q     <= 1'b0;
      cnt      <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      is_mod_q <= 1'b0;
    end else begin
      up_q <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          addr_q   <= in_addr;
          cnt      <= '0;
          res_q    <= simple_res;
          err_q    <= simple_err;
          a_neg_q  <= in_op_a[31];
          q_neg_q  <= in_op_a[31] ^ in_op_b[31];
          is_mod_q <= (in_opc == 4'd7);
          rem_q    <= '0;
          quo_q    <= in_op_a[31] ? -in_op_a : in_op_a;
          dvs_q    <= in_op_b[31] ? -in_op_b : in_op_b;
        end
        MUL: cnt <= cnt + 5'd1;
        DIV: begin
          cnt   <= cnt + 5'd1;
          rem_q <= rem_new;
          quo_q <= quo_new;
          if (cnt == DIV_LAST) res_q <= div_res;
        end
        default: ;
      endcase
    end
  end

`ifdef EXEC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_done <= '0;
      stat_err  <= '0;
    end else if (out_valid && out_ready) begin
      stat_done <= stat_done + 32'd1;
      if (err_q) stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized bench for instr_exec_unit against a plain-arithmetic reference model.
module tb_instr_exec_unit;
  localparam int MULT_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opc = '0;
  logic [31:0] in_op_a = '0;
  logic [31:0] in_op_b = '0;
  logic [4:0]  in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_res;
  logic [4:0]  out_addr;
  logic        out_err;
`ifdef EXEC_STATS_EN
  logic [31:0] stat_done;
  logic [15:0] stat_err;
`endif

  int n_chk = 0;
  int n_err = 0;
  int m_done = 0;
  int m_errs = 0;

  instr_exec_unit #(.MULT_LAT(MULT_LAT), .DIV_ITERS(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_addr(out_addr), .out_err(out_err)
`ifdef EXEC_STATS_EN
    , .stat_done(stat_done), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: signed 64-bit arithmetic straight from the opcode table.
  function automatic void model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] res, output logic err, output int lat);
    longint sa, sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    err = 1'b0;
    lat = 1;
    case (opc)
      4'd0: res = '0;
      4'd1: res = sa;
      4'd2: res = sb;
      4'd3: res = sa + sb;
      4'd4: res = sa - sb;
      4'd5: begin res = sa * sb; lat = MULT_LAT; end
      4'd6: if (sb == 0) err = 1'b1; else begin res = sa / sb; lat = 33; end
      4'd7: if (sb == 0) err = 1'b1; else begin res = sa % sb; lat = 33; end
      default: err = 1'b1;
    endcase
  endfunction

  task automatic send(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] addr);
    int w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    chk("ready_before_send", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_opc   = opc;
    in_op_a  = a;
    in_op_b  = b;
    in_addr  = addr;
    tick();
    in_valid = 1'b0;
    in_opc   = 4'($urandom);
    in_op_a  = $urandom;
    in_op_b  = $urandom;
    in_addr  = 5'($urandom);
  endtask

  task automatic finish_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] addr, input int hold);
    logic [63:0] er;
    logic        ee;
    int          el;
    int          lat = 1;
    model(opc, a, b, er, ee, el);
    while (!out_valid && lat < 60) begin
      chk("busy_ready_low", 64'(in_ready), 64'd0);
      tick();
      lat++;
    end
    chk($sformatf("latency opc=%0d", opc), 64'(lat), 64'(el));
    chk($sformatf("res opc=%0d a=%h b=%h", opc, a, b), out_res, er);
    chk("addr", 64'(out_addr), 64'(addr));
    chk($sformatf("err opc=%0d", opc), 64'(out_err), 64'(ee));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_res", out_res, er);
      chk("hold_tag", {58'd0, out_err, out_addr}, {58'd0, ee, addr});
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_done++;
    if (ee) m_errs++;
    chk("consumed_valid", 64'(out_valid), 64'd0);
    chk("ready_after", 64'(in_ready), 64'd1);
  endtask

  task automatic op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] addr, input int hold);
    send(opc, a, b, addr);
    finish_op(opc, a, b, addr, hold);
  endtask

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out", {out_res}, 64'd0);
    chk("rst_flags", {57'd0, out_valid, out_err, out_addr}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ready_after_release", 64'(in_ready), 64'd1);

    op(4'd3, 7, -10, 5'd3, 0);
    op(4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd4, 0);
    op(4'd6, -7, 2, 5'd5, 1);
    op(4'd7, -7, 2, 5'd6, 0);
    op(4'd6, 32'h8000_0000, -1, 5'd7, 0);
    op(4'd7, 32'h8000_0000, -1, 5'd8, 0);
    op(4'd6, 5, 0, 5'd9, 0);
    op(4'd12, 1, 2, 5'd10, 0);
    op(4'd4, 100, 250, 5'd11, 10);

    // Reset in the middle of a divide, then a fresh PASSA.
    send(4'd6, -100, 3, 5'd9);
    repeat (9) tick();
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_res", out_res, 64'd0);
    chk("midrst_tag", {58'd0, out_err, out_addr}, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    m_done = 0;
    m_errs = 0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ready_after_midrst", 64'(in_ready), 64'd1);
    op(4'd1, 42, 0, 5'd2, 0);
`ifdef EXEC_STATS_EN
    chk("stat_done_after_rst", 64'(stat_done), 64'(m_done));
`endif

    for (int i = 0; i < 60; i++) begin
      logic [3:0] opc;
      opc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      op(opc, pick(), pick(), 5'($urandom), $urandom_range(0, 3));
    end

`ifdef EXEC_STATS_EN
    chk("stat_done", 64'(stat_done), 64'(m_done));
    chk("stat_err", 64'(stat_err), 64'(m_errs));
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
